// File: rtl/lcd_pixel_stream_unpacker.sv
// lcd_pixel_stream_unpacker
// Read-clock-domain consumer of the LCD pixel FIFO's Avalon-ST source. It
// accepts 64-bit beats at ready latency 1, splits each beat into two 24-bit
// RGB pixels, and enforces the frame length. The result is a ready/valid
// pixel stream with start/end-of-frame markers. Malformed packets are flagged
// and resynchronised, so the panel never receives a partial or overlong frame.
//
// Ports:
//   clk, reset_n        pixel clock, asynchronous active-low reset
//   sink_*              Avalon-ST sink (data/empty/sop/eop/valid in, ready out)
//   pixel_data/valid    pixel stream out; pixel_ready in (ready latency 0)
//   pixel_sof/eof       first/last pixel of frame markers
//   err_short/long/nosop one-cycle error pulses
//   frame_count         completed frames, wraps at 16 bits
module lcd_pixel_stream_unpacker #(
    parameter int unsigned FRAME_PIXELS = 384000,
    parameter int unsigned PIX_CNT_W    = 19
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] sink_data,
    input  logic [2:0]  sink_empty,
    input  logic        sink_startofpacket,
    input  logic        sink_endofpacket,
    input  logic        sink_valid,
    output logic        sink_ready,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic        pixel_sof,
    output logic        pixel_eof,
    output logic        err_short,
    output logic        err_long,
    output logic        err_nosop,
    output logic [15:0] frame_count
);

    typedef enum logic [1:0] {IDLE, FRAME, DISCARD} state_t;

    localparam logic [PIX_CNT_W-1:0] LAST_CNT = PIX_CNT_W'(FRAME_PIXELS - 1);

    state_t state, state_nx;

    logic                 run;
    logic [23:0]          buf_p0 [2];
    logic [23:0]          buf_p1 [2];
    logic [1:0]           buf_sop, buf_eop, buf_lh;
    logic                 wr_ptr, rd_ptr;
    logic [1:0]           occ;
    logic                 arrive, pop;
    logic [2:0]           occ_after;

    logic                 head_valid, head_sop, head_eop, head_lh;
    logic                 half, half_nx;
    logic [PIX_CNT_W-1:0] pixel_cnt, cnt_nx;
    logic                 final_pix, at_last;
    logic                 short_nx, long_nx, nosop_nx, fc_inc;

    // The byte lanes above each pixel carry no information.
    logic unused_bits;
    assign unused_bits = ^{sink_data[63:56], sink_data[31:24]};

    // Ready latency 1: a beat may land the cycle after ready, so sink_ready
    // only asserts while the post-cycle occupancy leaves one free slot.
    assign arrive     = sink_valid;
    assign occ_after  = {1'b0, occ} + {2'b0, arrive} - {2'b0, pop};
    assign sink_ready = run && (occ_after <= 3'd1);

    assign head_valid = (occ != 2'd0);
    assign head_sop   = buf_sop[rd_ptr];
    assign head_eop   = buf_eop[rd_ptr];
    assign head_lh    = buf_lh[rd_ptr];
    assign pixel_data = half ? buf_p1[rd_ptr] : buf_p0[rd_ptr];
    assign final_pix  = half || head_lh;
    assign at_last    = (pixel_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (arrive) begin
            buf_p0[wr_ptr] <= sink_data[55:32];
            buf_p1[wr_ptr] <= sink_data[23:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run     <= 1'b0;
            buf_sop <= '0;
            buf_eop <= '0;
            buf_lh  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            occ     <= '0;
        end else begin
            run <= 1'b1;
            if (arrive) begin
                buf_sop[wr_ptr] <= sink_startofpacket;
                buf_eop[wr_ptr] <= sink_endofpacket;
                // Any non-zero empty on an EOP beat means only pixel0 is valid.
                buf_lh[wr_ptr]  <= sink_endofpacket && (sink_empty != 3'd0);
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ_after[1:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            half        <= 1'b0;
            pixel_cnt   <= '0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            err_nosop   <= 1'b0;
            frame_count <= '0;
        end else begin
            state     <= state_nx;
            half      <= half_nx;
            pixel_cnt <= cnt_nx;
            err_short <= short_nx;
            err_long  <= long_nx;
            err_nosop <= nosop_nx;
            if (fc_inc) frame_count <= frame_count + 16'd1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        half_nx  = half;
        cnt_nx   = pixel_cnt;
        short_nx = 1'b0;
        long_nx  = 1'b0;
        nosop_nx = 1'b0;
        fc_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (head_valid) begin
                    if (head_sop) begin
                        state_nx = FRAME;
                        cnt_nx   = '0;
                        half_nx  = 1'b0;
                    end else begin
                        pop      = 1'b1;
                        nosop_nx = 1'b1;
                    end
                end
            end
            FRAME: begin
                if (head_valid) begin
                    // A fresh SOP beat (half==0) after pixels were accepted
                    // truncates the old frame; the beat is kept as the new head.
                    if (head_sop && !half && (pixel_cnt != '0)) begin
                        short_nx = 1'b1;
                        cnt_nx   = '0;
                    end else if (pixel_ready) begin
                        cnt_nx = pixel_cnt + PIX_CNT_W'(1);
                        if (at_last) begin
                            pop      = 1'b1;
                            half_nx  = 1'b0;
                            fc_inc   = 1'b1;
                            long_nx  = !(head_eop && final_pix);
                            state_nx = head_eop ? IDLE : DISCARD;
                        end else if (final_pix) begin
                            pop     = 1'b1;
                            half_nx = 1'b0;
                            if (head_eop) begin
                                short_nx = 1'b1;
                                state_nx = IDLE;
                            end
                        end else begin
                            half_nx = 1'b1;
                        end
                    end
                end
            end
            DISCARD: begin
                if (head_valid) begin
                    if (head_sop) begin
                        state_nx = FRAME;
                        cnt_nx   = '0;
                        half_nx  = 1'b0;
                    end else begin
                        pop = 1'b1;
                        if (head_eop) state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
        pixel_eof   = 1'b0;
        if (state == FRAME && head_valid && !(head_sop && !half && (pixel_cnt != '0))) begin
            pixel_valid = 1'b1;
            pixel_sof   = (pixel_cnt == '0);
            pixel_eof   = at_last || (final_pix && head_eop);
        end
    end

endmodule

// File: doc/lcd_pixel_stream_unpacker.md
Name: lcd_pixel_stream_unpacker

Overview:
Reader-side consumer for the LCD pixel FIFO's Avalon-ST source, in the FIFO read-clock domain. Accepts 64-bit packet beats at ready latency 1 and splits each beat into two 24-bit RGB pixels. Enforces frame length, and presents a ready/valid pixel stream with start/end-of-frame markers to the LCD timing/serializer stage. Malformed packets are flagged and resynchronised so the panel never sees a partial or overlong frame.

Parameters:
FRAME_PIXELS, 384000, pixels per frame (800x480); must be even and >= 2
PIX_CNT_W, 19, width of pixel counter; must satisfy 2^PIX_CNT_W > FRAME_PIXELS

Ports:
clk  in  1  read-side pixel clock
reset_n  in  1  asynchronous active-low reset
sink_data  in  64  beat; pixel0 = [55:32], pixel1 = [23:0]; bits [63:56], [31:24] ignored
sink_empty  in  3  empty bytes in beat; legal 0 or 4, meaningful only with sink_endofpacket
sink_startofpacket  in  1  first beat of frame
sink_endofpacket  in  1  last beat of frame
sink_valid  in  1  beat present; only legal the cycle after sink_ready was high
sink_ready  out  1  permits one beat on the next cycle (ready latency 1)
pixel_data  out  24  RGB pixel
pixel_valid  out  1  pixel present
pixel_ready  in  1  downstream accepts pixel (ready latency 0)
pixel_sof  out  1  qualifies first pixel of frame
pixel_eof  out  1  qualifies last pixel of frame
err_short  out  1  one-cycle pulse: frame ended before FRAME_PIXELS
err_long  out  1  one-cycle pulse: FRAME_PIXELS reached without end of packet
err_nosop  out  1  one-cycle pulse: beat discarded while waiting for SOP
frame_count  out  16  completed frames (pixel_eof accepted), wraps at 65535->0

Behaviour:
- Reset: sink_ready=0, pixel_valid=0, pixel_sof=0, pixel_eof=0, all err_*=0, frame_count=0, buffer empty, state IDLE. The run flop sets on the first clk after release; sink_ready may rise from then on.
- Beat buffer: 2-entry FIFO. Each entry holds the 2 pixels, sop, eop, and last_half (1 when eop and empty==4).
- Arrival: on a cycle with sink_valid, write the beat at that edge. No check against sink_ready that cycle.
- Flow control: sink_ready = run & (occ + arrive - pop <= 1), combinational. Guarantees room for the beat that may land next cycle.
- Beat-to-pixel latency: beat written at edge N drives pixel_valid from cycle N+1 when it is the buffer head.
- Pixel ordering: half=0 selects pixel0, half=1 selects pixel1.
  - Pop the head when its final pixel is accepted: pixel1, or pixel0 if last_half.
  - half returns to 0 after each pop.
- Illegal empty: sink_empty not 0 or 4 on an EOP beat is treated as 4. No separate flag.
- State machine:
  - IDLE: head beat without sop is popped in 1 cycle, pixel_valid=0, err_nosop pulses. Head with sop goes to FRAME; pixel_cnt=0; first pixel carries pixel_sof.
  - FRAME: each accepted pixel increments pixel_cnt.
    - pixel_eof is asserted on the pixel where pixel_cnt==FRAME_PIXELS-1, or on the beat's final pixel when eop.
    - Accepting the eof pixel increments frame_count and returns to IDLE if the count was complete.
    - eop with pixel_cnt < FRAME_PIXELS-1: eof still asserted, err_short pulses on acceptance, go to IDLE. frame_count is not incremented.
  - FRAME, sop on a non-first head beat: truncation. err_short pulses and no eof is emitted for the old frame. The beat restarts the frame: pixel_cnt=0, pixel_sof on its pixel0.
  - FRAME, count reaches FRAME_PIXELS-1 and that pixel's beat lacks eop: emit the pixel with pixel_eof, pulse err_long, go to DISCARD. Pixel1 of that beat is dropped when pixel0 was the eof pixel.
  - DISCARD: pop one head beat per cycle, pixel_valid=0, until a beat with eop is popped → IDLE. A beat with sop in DISCARD → go directly to FRAME with that beat (no pulse).
- Output stability: pixel_data/sof/eof are held stable while pixel_valid & !pixel_ready.
- Simultaneous push and pop: occ unchanged. The FIFO pointers wrap mod 2.
- Asynchronous reset mid-frame: clears all state and drops buffered beats immediately. The next accepted pixel requires a fresh SOP.

Test Plan:
- FRAME_PIXELS=8, 4 beats sop..eop, empty=0, pixel_ready=1 -> 8 pixels in order p0,p1 of each beat; sof on pixel 0 and eof on pixel 7 only; frame_count 0->1; no err.
- Same stream with pixel_ready toggling 1010…, source valid exactly one cycle after ready -> no beat lost/overwritten; occ never >2; output identical to above.
- FRAME_PIXELS=8, 3 beats with eop on beat 2 and empty=4 -> 5 pixels; eof on pixel 4; err_short one pulse; frame_count unchanged.
- FRAME_PIXELS=8, 6 beats, eop on beat 5 -> 8 pixels; err_long pulse after pixel 7 accepted; beats 4-5 dropped; next sop frame outputs normally.
- Beat without sop in IDLE (2 beats), then valid frame -> 2 err_nosop pulses; no pixel_valid until sop beat; frame then passes intact.
- Assert reset_n=0 mid-frame after 3 pixels -> all outputs 0, frame_count=0; after release, leftover non-sop beats give err_nosop and the next sop frame completes.
